// File: rtl/jk_pkg.sv
// jk_pkg: shared mode encoding and JK truth-table codes for jk_counter_reg
package jk_pkg;
  typedef enum logic [1:0] {JK_MODE_JK, JK_MODE_UP, JK_MODE_DN, JK_MODE_LD} jk_mode_e;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK bit with synchronous reset, enable and load override
module jk_cell
  import jk_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic CE,
  input  logic rst_val,
  input  logic ld,
  input  logic d,
  input  logic j,
  input  logic k,
  output logic q
);
  logic q_d, q_q;
  always_comb
    q_d = !CE ? q_q :
          ld ? d :
          {j, k} == JK_TGL ? ~q_q :
          {j, k} == JK_SET ? 1'b1 :
          {j, k} == JK_CLR ? 1'b0 : q_q;
  always_ff @(posedge CLK)
    q_q <= RST ? rst_val : q_d;
  assign q = q_q;
endmodule

// File: rtl/jk_counter_reg.sv
// jk_counter_reg: JK register bank with up/down toggle-chain counting, load, TC and sticky OVF
module jk_counter_reg
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             TC,
  output logic             OVF
);
  jk_mode_e mode;
  logic ld, ovf_d, ovf_q;
  assign mode = jk_mode_e'(MODE);
  assign ld = mode == JK_MODE_LD;
  assign QB = ~Q;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic t_up, t_dn, cj, ck;
      if (i == 0) begin : g_lsb
        assign t_up = 1'b1;
        assign t_dn = 1'b1;
      end else begin : g_chain
        assign t_up = &Q[i-1:0];
        assign t_dn = &QB[i-1:0];
      end
      always_comb begin
        cj = mode == JK_MODE_JK ? J[i] : mode == JK_MODE_UP ? t_up : mode == JK_MODE_DN ? t_dn : 1'b0;
        ck = mode == JK_MODE_JK ? K[i] : mode == JK_MODE_UP ? t_up : mode == JK_MODE_DN ? t_dn : 1'b0;
      end
      jk_cell u_cell (
        .CLK    (CLK),
        .RST    (RST),
        .CE     (CE),
        .rst_val(RST_VAL[i]),
        .ld     (ld),
        .d      (D[i]),
        .j      (cj),
        .k      (ck),
        .q      (Q[i])
      );
    end
  endgenerate
  assign TC = CE & ~RST & ((mode == JK_MODE_UP & (&Q)) | (mode == JK_MODE_DN & ~(|Q)));
  always_comb
    ovf_d = !CE ? ovf_q : ld ? 1'b0 : TC ? 1'b1 : ovf_q;
  always_ff @(posedge CLK)
    ovf_q <= RST ? 1'b0 : ovf_d;
  assign OVF = ovf_q;
endmodule

// File: tb/tb_jk_counter_reg.sv
// tb_jk_counter_reg: directed scoreboard bench for two jk_counter_reg instances (RST_VAL 0 and 8'h3C)
module tb_jk_counter_reg;
  logic clk = 1'b0;
  logic rst = 1'b0, ce = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] j = '0, k = '0, d = '0;
  logic [7:0] q0, qb0, q1, qb1;
  logic tc0, tc1, ovf0, ovf1;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] q0;
    logic       o0;
    logic [7:0] q1;
    logic       o1;
    string      tag;
  } exp_t;
  exp_t sb[$];
  logic [7:0] mq0 = '0, mq1 = '0;
  logic mo0 = 1'b0, mo1 = 1'b0;
  always #5 clk = ~clk;
  jk_counter_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_dut0 (
    .CLK(clk), .RST(rst), .CE(ce), .MODE(mode), .J(j), .K(k), .D(d),
    .Q(q0), .QB(qb0), .TC(tc0), .OVF(ovf0)
  );
  jk_counter_reg #(.WIDTH(8), .RST_VAL(8'h3C)) u_dut1 (
    .CLK(clk), .RST(rst), .CE(ce), .MODE(mode), .J(j), .K(k), .D(d),
    .Q(q1), .QB(qb1), .TC(tc1), .OVF(ovf1)
  );
  function automatic logic [8:0] nxt(input logic [7:0] q, input logic ovf, input logic r, input logic e,
                                     input logic [1:0] m, input logic [7:0] jj, input logic [7:0] kk,
                                     input logic [7:0] dd, input logic [7:0] rv);
    if (r) return {1'b0, rv};
    if (!e) return {ovf, q};
    case (m)
      2'b00:   return {ovf, (jj & ~q) | (~kk & q)};
      2'b01:   return {ovf | (q == 8'hFF), 8'(q + 8'd1)};
      2'b10:   return {ovf | (q == 8'h00), 8'(q - 8'd1)};
      default: return {1'b0, dd};
    endcase
  endfunction
  function automatic logic exp_tc(input logic [7:0] q, input logic r, input logic e, input logic [1:0] m);
    return e & ~r & ((m == 2'b01 && q == 8'hFF) || (m == 2'b10 && q == 8'h00));
  endfunction
  task automatic chk1(input logic a, input logic b, input string tag);
    checks++;
    assert (a === b) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, a, b);
    end
  endtask
  task automatic chk8(input logic [7:0] a, input logic [7:0] b, input string tag);
    checks++;
    assert (a === b) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, a, b);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [7:0] jj,
                      input logic [7:0] kk, input logic [7:0] dd, input string tag);
    logic [8:0] n0, n1;
    exp_t x;
    @(negedge clk);
    rst = r; ce = e; mode = m; j = jj; k = kk; d = dd;
    #1;
    chk1(tc0, exp_tc(mq0, r, e, m), {tag, " tc0"});
    chk1(tc1, exp_tc(mq1, r, e, m), {tag, " tc1"});
    n0 = nxt(mq0, mo0, r, e, m, jj, kk, dd, 8'h00);
    n1 = nxt(mq1, mo1, r, e, m, jj, kk, dd, 8'h3C);
    {mo0, mq0} = n0;
    {mo1, mq1} = n1;
    sb.push_back('{q0: mq0, o0: mo0, q1: mq1, o1: mo1, tag: tag});
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard: got empty queue expected one entry", tag);
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk8(q0, x.q0, {x.tag, " q0"});
      chk8(qb0, ~x.q0, {x.tag, " qb0"});
      chk1(ovf0, x.o0, {x.tag, " ovf0"});
      chk8(q1, x.q1, {x.tag, " q1"});
      chk8(qb1, ~x.q1, {x.tag, " qb1"});
      chk1(ovf1, x.o1, {x.tag, " ovf1"});
    end
  endtask
  initial begin
    step(1, 1, 2'b11, 8'h00, 8'h00, 8'hAA, "reset_prio");
    chk8(q0, 8'h00, "reset q0 const");
    chk8(q1, 8'h3C, "reset q1 const");
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'hF0, "t1 load");
    step(0, 1, 2'b00, 8'hCC, 8'hAA, 8'h00, "t1 jk");
    chk8(q0, 8'h5C, "t1 q const");
    chk8(qb0, 8'hA3, "t1 qb const");
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'hFE, "t2 load");
    step(0, 1, 2'b01, 8'h5A, 8'hA5, 8'h33, "t2 up1");
    step(0, 1, 2'b01, 8'hFF, 8'h00, 8'h77, "t2 up2 wrap");
    chk1(ovf0, 1'b1, "t2 ovf const");
    step(0, 1, 2'b01, 8'h00, 8'hFF, 8'h00, "t2 up3");
    chk8(q0, 8'h01, "t2 q const");
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'h01, "t3 load");
    step(0, 1, 2'b10, 8'h00, 8'h00, 8'h00, "t3 dn1");
    step(0, 1, 2'b10, 8'h12, 8'h34, 8'h56, "t3 dn2 wrap");
    chk8(q0, 8'hFF, "t3 q const");
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'h10, "t3 load clr");
    chk1(ovf0, 1'b0, "t3 ovf const");
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'h00, "t4 load");
    step(0, 1, 2'b10, 8'h00, 8'h00, 8'h00, "t4 dn wrap");
    step(0, 1, 2'b00, 8'h00, 8'hFA, 8'h00, "t4 jk clr");
    for (int n = 0; n < 3; n++) step(0, 0, 2'b01, 8'hFF, 8'hFF, 8'hFF, "t4 hold");
    chk8(q0, 8'h05, "t4 q const");
    step(0, 1, 2'b01, 8'h00, 8'h00, 8'h00, "t4 resume");
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'hFF, "t4b load ff");
    step(0, 0, 2'b01, 8'h00, 8'h00, 8'h00, "t4b ce0 tc");
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'h7F, "t6 load");
    step(0, 1, 2'b01, 8'h00, 8'h00, 8'h00, "t6 up1");
    step(0, 1, 2'b01, 8'h00, 8'h00, 8'h00, "t6 up2");
    step(1, 1, 2'b01, 8'h00, 8'h00, 8'h00, "t6 rst");
    step(0, 1, 2'b01, 8'h00, 8'h00, 8'h00, "t6 resume");
    chk8(q1, 8'h3D, "t6 q1 const");
    for (int n = 0; n < 6; n++)
      step(0, 1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), "rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
